// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle core: run/halt/step control, breakpoint, misaligned-target trap.
// Requests sampled at an edge change state at that edge; the first execute happens on the following cycle.
module pc_sequencer #(
  parameter int                    PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_VEC = '0,
  parameter int                    CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 run_req,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_tgt,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_tgt,
  input  logic                 jr,
  input  logic [PC_WIDTH-1:0]  jr_tgt,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_plus4,
  output logic                 exec,
  output logic [1:0]           state,
  output logic [PC_WIDTH-1:0]  fault_pc,
  output logic [CNT_WIDTH-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_FAULT = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  fault_pc_q, fault_pc_d;
  logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

  logic [PC_WIDTH-1:0]  tgt;
  logic [PC_WIDTH-1:0]  next_pc;
  logic                 tgt_sel;
  logic                 misaligned;
  logic                 issue;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  always_comb begin
    tgt_sel = 1'b1;
    tgt     = '0;
    if (jr) begin
      tgt = jr_tgt;
    end else if (jump) begin
      tgt = jump_tgt;
    end else if (branch_taken) begin
      tgt = branch_tgt;
    end else begin
      tgt_sel = 1'b0;
    end
    // Only explicit control-flow targets can be misaligned; the sequential path never is.
    misaligned = tgt_sel && (tgt[1:0] != 2'b00);
    next_pc    = tgt_sel ? tgt : pc_plus4;
    issue      = ((state_q == S_RUN) && !halt_req) || (state_q == S_STEP);
    exec       = issue && !misaligned;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_pc_d   = fault_pc_q;
    retire_cnt_d = retire_cnt_q;

    if (exec) begin
      pc_d         = next_pc;
      retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
    end

    if (issue && misaligned) begin
      fault_pc_d = pc_q;
      state_d    = S_FAULT;
    end else begin
      case (state_q)
        S_HALT: begin
          if (!halt_req) begin
            if (run_req) begin
              state_d = S_RUN;
            end else if (step_req) begin
              state_d = S_STEP;
            end
          end
        end
        S_RUN: begin
          // Breakpoint looks at the address about to be fetched, so resuming at bp_addr does not re-trigger.
          if (halt_req) begin
            state_d = S_HALT;
          end else if (bp_en && (next_pc == bp_addr)) begin
            state_d = S_HALT;
          end
        end
        S_STEP:  state_d = S_HALT;
        default: state_d = S_FAULT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_HALT;
      pc_q         <= RESET_VEC;
      fault_pc_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_pc_q   <= fault_pc_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign state      = state_q;
  assign fault_pc   = fault_pc_q;
  assign retire_cnt = retire_cnt_q;

endmodule
